// File: rtl/adma2_pkg.sv
// Shared encodings for the ADMA2 descriptor engine: FSM states, Act codes,
// error-state codes and descriptor bit positions.
// Pure definitions, no logic.
package adma2_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_CADR = 2'b10,
    ST_TFR  = 2'b11
  } adma_state_e;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_e;

  localparam logic [1:0] ERR_ST_STOP = 2'b00;
  localparam logic [1:0] ERR_ST_FDS  = 2'b01;
  localparam logic [1:0] ERR_ST_TFR  = 2'b11;

  localparam int DESC_VALID_BIT = 0;
  localparam int DESC_END_BIT   = 1;
  localparam int DESC_INT_BIT   = 2;
  localparam int DESC_ACT_LSB   = 4;
  localparam int DESC_LEN_LSB   = 16;
  localparam int DESC_ADDR_LSB  = 32;

  // A Length field of zero encodes the maximum 65536-byte transfer.
  function automatic logic [16:0] expand_len(input logic [15:0] len);
    return {len == 16'd0, len};
  endfunction

endpackage

// File: rtl/adma2_desc_decode.sv
// Descriptor field extraction with Length-0 expansion and Valid flag.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs on desc_ack.
module adma2_desc_decode
  import adma2_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DESC_W = ADDR_W + 32
) (
  input  logic [DESC_W-1:0] desc_i,
  output logic              valid_o,
  output logic              end_o,
  output logic              int_o,
  output adma_act_e         act_o,
  output logic [16:0]       len_o,
  output logic [ADDR_W-1:0] addr_o
);

  assign valid_o = desc_i[DESC_VALID_BIT];
  assign end_o   = desc_i[DESC_END_BIT];
  assign int_o   = desc_i[DESC_INT_BIT];
  assign act_o   = adma_act_e'(desc_i[DESC_ACT_LSB +: 2]);
  assign len_o   = expand_len(desc_i[DESC_LEN_LSB +: 16]);
  assign addr_o  = desc_i[DESC_ADDR_LSB +: ADDR_W];

  // Reserved attribute bits carry no meaning for the engine.
  logic unused_bits;
  assign unused_bits = ^{desc_i[3], desc_i[15:6]};

endmodule

// File: rtl/adma2_engine.sv
// ADMA2 descriptor engine: fetches, decodes and executes NOP/RSV/TRAN/LINK chains.
// Latency: descriptor executes one cycle after desc_ack; transfer launches from ST_CADR.
// Backpressure: holds desc_req until desc_ack, waits in ST_TFR until tfr_done.
module adma2_engine
  import adma2_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DESC_W      = ADDR_W + 32,
  parameter int DESC_STRIDE = DESC_W / 8,
  parameter int LINK_MAX    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resume,
  input  logic [ADDR_W-1:0] sys_addr_in,
  input  logic              stop_req,
  input  logic              abort,
  output logic              desc_req,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic              desc_ack,
  input  logic [DESC_W-1:0] desc_data,
  input  logic              desc_err,
  output logic              tfr_start,
  output logic [ADDR_W-1:0] tfr_addr,
  output logic [16:0]       tfr_len,
  input  logic              tfr_done,
  input  logic              tfr_err,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              xfer_complete,
  output logic              dma_int,
  output logic              paused,
  output logic              adma_error,
  output logic [1:0]        err_state
);

  localparam int                LCNT_W   = $clog2(LINK_MAX + 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DESC_STRIDE);
  localparam logic [LCNT_W-1:0] LINK_LIM = LCNT_W'(LINK_MAX);

  adma_state_e       state_q;
  logic [ADDR_W-1:0] cur_addr_q, desc_addr_q, tfr_addr_q, d_addr_q;
  logic [16:0]       tfr_len_q, d_len_q;
  logic [1:0]        err_state_q;
  logic [LCNT_W-1:0] link_cnt_q;
  logic              desc_req_q, tfr_start_q, xfer_complete_q, dma_int_q;
  logic              paused_q, adma_error_q, stop_seen_q, d_end_q, d_int_q;
  adma_act_e         d_act_q;

  logic              dec_valid, dec_end, dec_int;
  adma_act_e         dec_act;
  logic [16:0]       dec_len;
  logic [ADDR_W-1:0] dec_addr;

  adma2_desc_decode #(.ADDR_W(ADDR_W), .DESC_W(DESC_W)) u_decode (
    .desc_i  (desc_data),
    .valid_o (dec_valid),
    .end_o   (dec_end),
    .int_o   (dec_int),
    .act_o   (dec_act),
    .len_o   (dec_len),
    .addr_o  (dec_addr)
  );

  // Sequential next address (wraps naturally) and next link count.
  logic [ADDR_W-1:0] seq_addr_d;
  logic [LCNT_W-1:0] link_cnt_d;
  logic              aligned_d;
  assign seq_addr_d = cur_addr_q + STRIDE;
  assign link_cnt_d = link_cnt_q + LCNT_W'(1);
  assign aligned_d  = (cur_addr_q % STRIDE) == '0;

  // Main FSM; every output is a register, pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_STOP;
      cur_addr_q      <= '0;
      desc_addr_q     <= '0;
      tfr_addr_q      <= '0;
      tfr_len_q       <= '0;
      d_addr_q        <= '0;
      d_len_q         <= '0;
      d_act_q         <= ACT_NOP;
      d_end_q         <= 1'b0;
      d_int_q         <= 1'b0;
      err_state_q     <= ERR_ST_STOP;
      link_cnt_q      <= '0;
      desc_req_q      <= 1'b0;
      tfr_start_q     <= 1'b0;
      xfer_complete_q <= 1'b0;
      dma_int_q       <= 1'b0;
      paused_q        <= 1'b0;
      adma_error_q    <= 1'b0;
      stop_seen_q     <= 1'b0;
    end else begin
      tfr_start_q     <= 1'b0;
      xfer_complete_q <= 1'b0;
      dma_int_q       <= 1'b0;
      adma_error_q    <= 1'b0;
      // Block-gap request is remembered while running, forgotten once stopped.
      if (state_q == ST_STOP) stop_seen_q <= 1'b0;
      else if (stop_req)      stop_seen_q <= 1'b1;

      if (abort) begin
        state_q    <= ST_STOP;
        desc_req_q <= 1'b0;
        paused_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_STOP: begin
            if (start) begin
              if (!resume) cur_addr_q <= sys_addr_in;
              paused_q    <= 1'b0;
              err_state_q <= ERR_ST_STOP;
              link_cnt_q  <= '0;
              state_q     <= ST_FDS;
            end
          end
          ST_FDS: begin
            if (!desc_req_q) begin
              // Alignment is checked before any bus request goes out.
              if (!aligned_d) begin
                adma_error_q <= 1'b1;
                err_state_q  <= ERR_ST_FDS;
                state_q      <= ST_STOP;
              end else begin
                desc_req_q  <= 1'b1;
                desc_addr_q <= cur_addr_q;
              end
            end else if (desc_ack) begin
              desc_req_q <= 1'b0;
              d_end_q    <= dec_end;
              d_int_q    <= dec_int;
              d_act_q    <= dec_act;
              d_len_q    <= dec_len;
              d_addr_q   <= dec_addr;
              if (desc_err || !dec_valid) begin
                adma_error_q <= 1'b1;
                err_state_q  <= ERR_ST_FDS;
                state_q      <= ST_STOP;
              end else begin
                state_q <= ST_CADR;
              end
            end
          end
          ST_CADR: begin
            if (d_act_q == ACT_TRAN) begin
              cur_addr_q  <= seq_addr_d;
              tfr_start_q <= 1'b1;
              tfr_addr_q  <= d_addr_q;
              tfr_len_q   <= d_len_q;
              link_cnt_q  <= '0;
              state_q     <= ST_TFR;
            end else begin
              dma_int_q <= d_int_q;
              // Too many back-to-back non-TRAN lines: assume a descriptor loop.
              if (link_cnt_d == LINK_LIM) begin
                adma_error_q <= 1'b1;
                err_state_q  <= ERR_ST_FDS;
                state_q      <= ST_STOP;
              end else begin
                link_cnt_q <= link_cnt_d;
                cur_addr_q <= (d_act_q == ACT_LINK) ? d_addr_q : seq_addr_d;
                if (d_end_q) begin
                  xfer_complete_q <= 1'b1;
                  state_q         <= ST_STOP;
                end else begin
                  state_q <= ST_FDS;
                end
              end
            end
          end
          ST_TFR: begin
            if (tfr_done) begin
              if (tfr_err) begin
                adma_error_q <= 1'b1;
                err_state_q  <= ERR_ST_TFR;
                state_q      <= ST_STOP;
              end else begin
                dma_int_q <= d_int_q;
                if (d_end_q) begin
                  xfer_complete_q <= 1'b1;
                  state_q         <= ST_STOP;
                end else if (stop_seen_q || stop_req) begin
                  paused_q <= 1'b1;
                  state_q  <= ST_STOP;
                end else begin
                  state_q <= ST_FDS;
                end
              end
            end
          end
          default: state_q <= ST_STOP;
        endcase
      end
    end
  end

  assign busy          = (state_q != ST_STOP);
  assign cur_addr      = cur_addr_q;
  assign desc_req      = desc_req_q;
  assign desc_addr     = desc_addr_q;
  assign tfr_start     = tfr_start_q;
  assign tfr_addr      = tfr_addr_q;
  assign tfr_len       = tfr_len_q;
  assign xfer_complete = xfer_complete_q;
  assign dma_int       = dma_int_q;
  assign paused        = paused_q;
  assign adma_error    = adma_error_q;
  assign err_state     = err_state_q;

endmodule

// File: tb/tb_adma2_engine.sv
// Bench for adma2_engine: directed spec scenarios plus random descriptor chains
// checked against a descriptor-walking reference model; a 64-bit instance too.
`timescale 1ns/1ps
module tb_adma2_engine;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int STR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 0, resume = 0, stop_req = 0, abort = 0;
  logic desc_ack = 0, desc_err = 0, tfr_done = 0, tfr_err = 0;
  logic [AW-1:0] sys_addr_in = '0;
  logic [DW-1:0] desc_data = '0;
  logic desc_req, tfr_start, busy, xfer_complete, dma_int, paused, adma_error;
  logic [AW-1:0] desc_addr, tfr_addr, cur_addr;
  logic [16:0] tfr_len;
  logic [1:0] err_state;

  adma2_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resume(resume), .sys_addr_in(sys_addr_in),
    .stop_req(stop_req), .abort(abort), .desc_req(desc_req), .desc_addr(desc_addr),
    .desc_ack(desc_ack), .desc_data(desc_data), .desc_err(desc_err), .tfr_start(tfr_start),
    .tfr_addr(tfr_addr), .tfr_len(tfr_len), .tfr_done(tfr_done), .tfr_err(tfr_err),
    .busy(busy), .cur_addr(cur_addr), .xfer_complete(xfer_complete), .dma_int(dma_int),
    .paused(paused), .adma_error(adma_error), .err_state(err_state)
  );

  // 64-bit address instance
  logic start6 = 0, resume6 = 0, stop_req6 = 0, abort6 = 0;
  logic desc_ack6 = 0, desc_err6 = 0, tfr_done6 = 0, tfr_err6 = 0;
  logic [63:0] sys_addr6 = '0;
  logic [95:0] desc_data6 = '0;
  logic desc_req6, tfr_start6, busy6, xfer_complete6, dma_int6, paused6, adma_error6;
  logic [63:0] desc_addr6, tfr_addr6, cur_addr6;
  logic [16:0] tfr_len6;
  logic [1:0] err_state6;

  adma2_engine #(.ADDR_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start6), .resume(resume6), .sys_addr_in(sys_addr6),
    .stop_req(stop_req6), .abort(abort6), .desc_req(desc_req6), .desc_addr(desc_addr6),
    .desc_ack(desc_ack6), .desc_data(desc_data6), .desc_err(desc_err6), .tfr_start(tfr_start6),
    .tfr_addr(tfr_addr6), .tfr_len(tfr_len6), .tfr_done(tfr_done6), .tfr_err(tfr_err6),
    .busy(busy6), .cur_addr(cur_addr6), .xfer_complete(xfer_complete6), .dma_int(dma_int6),
    .paused(paused6), .adma_error(adma_error6), .err_state(err_state6)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Descriptor memory and bus-error map seen by the fetch responder and the model.
  logic [63:0] mem [logic [31:0]];
  bit berr [logic [31:0]];
  int stop_idx = -1, err_idx = -1;
  bit abort_mode = 0;

  logic [31:0] obs_fetch[$], obs_taddr[$], exp_fetch[$], exp_taddr[$];
  logic [16:0] obs_tlen[$], exp_tlen[$];
  int obs_int, obs_cpl, obs_err, exp_int, exp_cpl, exp_err;
  logic [1:0] exp_est;
  logic [31:0] exp_addr;
  bit exp_paused;

  function automatic logic [63:0] mkd(input bit vb, input bit eb, input bit ib,
                                      input logic [1:0] act, input logic [15:0] len,
                                      input logic [31:0] a);
    return {a, len, 10'd0, act, 1'b0, ib, eb, vb};
  endfunction

  function automatic logic [63:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // Reference: walk the chain as the descriptor rules describe it.
  task automatic model(input logic [31:0] a0);
    logic [31:0] a;
    logic [63:0] d;
    int links, ti;
    a = a0; links = 0; ti = 0;
    exp_fetch.delete(); exp_taddr.delete(); exp_tlen.delete();
    exp_int = 0; exp_cpl = 0; exp_err = 0; exp_est = 2'b00; exp_paused = 0;
    for (int g = 0; g < 1000; g++) begin
      if (a % STR != 0) begin exp_err = 1; exp_est = 2'b01; break; end
      exp_fetch.push_back(a);
      d = rd(a);
      if (berr.exists(a) || !d[0]) begin exp_err = 1; exp_est = 2'b01; break; end
      if (d[5:4] == 2'b10) begin
        exp_taddr.push_back(d[63:32]);
        exp_tlen.push_back(d[31:16] == 16'd0 ? 17'h10000 : {1'b0, d[31:16]});
        a = a + STR; links = 0;
        if (ti == err_idx) begin exp_err = 1; exp_est = 2'b11; break; end
        if (d[2]) exp_int++;
        if (d[1]) begin exp_cpl = 1; break; end
        if (ti == stop_idx) begin exp_paused = 1; break; end
        ti++;
      end else begin
        links++;
        if (d[2]) exp_int++;
        if (links == 16) begin exp_err = 1; exp_est = 2'b01; break; end
        a = (d[5:4] == 2'b11) ? d[63:32] : a + STR;
        if (d[1]) begin exp_cpl = 1; break; end
      end
    end
    exp_addr = a;
  endtask

  // Start the engine and act as descriptor memory and data path until it stops.
  task automatic run(input logic [31:0] a0, input bit res);
    int dwait, tcnt, ti, tidx, cyc;
    bit fin;
    dwait = 0; tcnt = 0; ti = 0; tidx = 0; cyc = 0; fin = 0;
    obs_fetch.delete(); obs_taddr.delete(); obs_tlen.delete();
    obs_int = 0; obs_cpl = 0; obs_err = 0;
    @(posedge clk); #1; start = 1; resume = res; sys_addr_in = a0;
    @(posedge clk); #1; start = 0; resume = 0;
    while (!fin && cyc < 3000) begin
      desc_ack = 0; desc_err = 0; desc_data = '0; tfr_done = 0; tfr_err = 0;
      stop_req = 0; abort = 0; start = 0;
      if (tfr_start) begin
        obs_taddr.push_back(tfr_addr); obs_tlen.push_back(tfr_len);
        tidx = ti; ti++;
        if (tidx == stop_idx) stop_req = 1;
        tcnt = $urandom_range(1, 5);
      end else if (tcnt > 0) begin
        tcnt--;
        if (tcnt == 0) begin
          tfr_done = 1; tfr_err = (tidx == err_idx);
          if (abort_mode) abort = 1;
        end
      end
      if (dma_int) obs_int++;
      if (xfer_complete) obs_cpl++;
      if (adma_error) obs_err++;
      if (desc_req) begin
        if (dwait == 0) begin
          desc_ack = 1; obs_fetch.push_back(desc_addr);
          desc_data = rd(desc_addr); desc_err = berr.exists(desc_addr);
          dwait = $urandom_range(0, 3);
        end else dwait--;
      end
      if (cyc == 2 && busy) begin start = 1; sys_addr_in = $urandom; end
      if (!busy) fin = 1;
      cyc++;
      @(posedge clk); #1;
    end
    start = 0; desc_ack = 0; tfr_done = 0; stop_req = 0; abort = 0;
    if (!fin) begin
      chk("run_timeout", 1, 0);
      abort = 1; @(posedge clk); #1; abort = 0;
    end
  endtask

  task automatic compare(input string t);
    chk({t, ":nfetch"}, obs_fetch.size(), exp_fetch.size());
    foreach (exp_fetch[i]) if (i < obs_fetch.size()) chk({t, ":fetch"}, obs_fetch[i], exp_fetch[i]);
    chk({t, ":ntfr"}, obs_taddr.size(), exp_taddr.size());
    foreach (exp_taddr[i]) if (i < obs_taddr.size()) begin
      chk({t, ":tfr_addr"}, obs_taddr[i], exp_taddr[i]);
      chk({t, ":tfr_len"}, obs_tlen[i], exp_tlen[i]);
    end
    chk({t, ":dma_int"}, obs_int, exp_int);
    chk({t, ":complete"}, obs_cpl, exp_cpl);
    chk({t, ":adma_error"}, obs_err, exp_err);
    chk({t, ":err_state"}, err_state, exp_est);
    chk({t, ":cur_addr"}, cur_addr, exp_addr);
    chk({t, ":paused"}, paused, exp_paused);
    chk({t, ":busy"}, busy, 0);
  endtask

  task automatic gen(input logic [31:0] base, input int n);
    logic [31:0] a, tgt;
    logic [1:0] act;
    logic [15:0] len;
    int k;
    bit v, e;
    mem.delete(); berr.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i * 8); k = $urandom_range(0, 99); tgt = $urandom; v = 1; e = 0;
      if (k < 50) act = 2'b10; else if (k < 60) act = 2'b00; else if (k < 70) act = 2'b01; else act = 2'b11;
      if (act == 2'b11) begin
        if (i < n - 1) tgt = base + 32'($urandom_range(i + 1, n - 1) * 8);
        else act = 2'b10;
      end
      if (i == n - 1 || $urandom_range(0, 15) == 0) e = 1;
      if ($urandom_range(0, 29) == 0) v = 0;
      len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      mem[a] = mkd(v, e, 1'($urandom_range(0, 1)), act, len, tgt);
      if ($urandom_range(0, 39) == 0) berr[a] = 1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst:ctrl", {busy, desc_req, tfr_start, xfer_complete, dma_int, paused, adma_error}, 0);
    chk("rst:addrs", {cur_addr, desc_addr}, 0);
    chk("rst:tfr", {tfr_addr, tfr_len, err_state}, 0);
    chk("rst:dut64", {busy6, cur_addr6, err_state6}, 0);
    rst_n = 1;

    // Single TRAN
    mem.delete(); berr.delete();
    mem[32'h1000] = mkd(1, 1, 0, 2'b10, 16'h0200, 32'h8000);
    model(32'h1000); run(32'h1000, 0); compare("single");
    chk("single:cur_addr_lit", cur_addr, 32'h1008);
    if (obs_tlen.size() > 0) chk("single:len_lit", obs_tlen[0], 17'h200);

    // TRAN, LINK, TRAN+End+Int
    mem.delete();
    mem[32'h1000] = mkd(1, 0, 0, 2'b10, 16'h0040, 32'hA000);
    mem[32'h1008] = mkd(1, 0, 0, 2'b11, 16'h0000, 32'h2000);
    mem[32'h2000] = mkd(1, 1, 1, 2'b10, 16'h0080, 32'hB000);
    model(32'h1000); run(32'h1000, 0); compare("chain");
    chk("chain:ntfr_lit", obs_taddr.size(), 2);
    chk("chain:int_lit", obs_int, 1);

    // Length 0 means 65536
    mem.delete();
    mem[32'h1000] = mkd(1, 1, 0, 2'b10, 16'h0000, 32'h9000);
    model(32'h1000); run(32'h1000, 0); compare("len0");
    if (obs_tlen.size() > 0) chk("len0:len_lit", obs_tlen[0], 17'h10000);

    // Valid=0
    mem.delete();
    mem[32'h1000] = mkd(0, 1, 0, 2'b10, 16'h0010, 32'h9000);
    model(32'h1000); run(32'h1000, 0); compare("invalid");
    chk("invalid:est_lit", err_state, 2'b01);
    chk("invalid:addr_lit", cur_addr, 32'h1000);

    // Transfer error
    mem.delete();
    mem[32'h1000] = mkd(1, 1, 1, 2'b10, 16'h0010, 32'h9000);
    err_idx = 0;
    model(32'h1000); run(32'h1000, 0); compare("tfr_err");
    chk("tfr_err:est_lit", err_state, 2'b11);
    err_idx = -1;

    // Misaligned start
    model(32'h1004); run(32'h1004, 0); compare("misalign");
    chk("misalign:nfetch_lit", obs_fetch.size(), 0);

    // LINK to itself
    mem.delete();
    mem[32'h3000] = mkd(1, 0, 0, 2'b11, 16'h0000, 32'h3000);
    model(32'h3000); run(32'h3000, 0); compare("loop");
    chk("loop:nfetch_lit", obs_fetch.size(), 16);

    // Stop at block gap, then continue
    mem.delete();
    mem[32'h1000] = mkd(1, 0, 0, 2'b10, 16'h0020, 32'h4000);
    mem[32'h1008] = mkd(1, 1, 0, 2'b10, 16'h0030, 32'h5000);
    stop_idx = 0;
    model(32'h1000); run(32'h1000, 0); compare("pause");
    chk("pause:paused_lit", paused, 1);
    stop_idx = -1;
    model(32'h1008); run(32'hDEAD_0000, 1); compare("resume");
    if (obs_fetch.size() > 0) chk("resume:first_lit", obs_fetch[0], 32'h1008);

    // Abort coincident with tfr_done
    mem.delete();
    mem[32'h1000] = mkd(1, 1, 1, 2'b10, 16'h0020, 32'h4000);
    abort_mode = 1;
    run(32'h1000, 0);
    abort_mode = 0;
    chk("abort:ntfr", obs_taddr.size(), 1);
    chk("abort:pulses", {obs_int[7:0], obs_cpl[7:0], obs_err[7:0]}, 0);
    chk("abort:busy_paused", {busy, paused}, 0);

    // Random chains (first one wraps past 2^32)
    for (int r = 0; r < 40; r++) begin
      base = (r == 0) ? 32'hFFFF_FFF0 : {$urandom_range(1, 32'h0FFF_FFFF), 3'b000};
      gen(base, $urandom_range(2, 10));
      stop_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      err_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      model(base); run(base, 0); compare("rand");
    end
    stop_idx = -1; err_idx = -1;

    // Reset in the middle of a transfer
    mem.delete();
    mem[32'h1000] = mkd(1, 1, 0, 2'b10, 16'h0010, 32'h5000);
    @(posedge clk); #1; start = 1; sys_addr_in = 32'h1000;
    @(posedge clk); #1; start = 0;
    for (int c = 0; c < 20 && !desc_req; c++) begin @(posedge clk); #1; end
    desc_ack = 1; desc_data = rd(32'h1000);
    @(posedge clk); #1; desc_ack = 0;
    for (int c = 0; c < 20 && !tfr_start; c++) begin @(posedge clk); #1; end
    chk("rstmid:busy_before", busy, 1);
    #2; rst_n = 0; #1;
    chk("rstmid:busy", busy, 0);
    chk("rstmid:addrs", {cur_addr, tfr_addr}, 0);
    @(posedge clk); #1; rst_n = 1;

    // 64-bit addressing: stride 12
    @(posedge clk); #1; start6 = 1; sys_addr6 = 64'hC000;
    @(posedge clk); #1; start6 = 0;
    for (int c = 0; c < 20 && !desc_req6; c++) begin @(posedge clk); #1; end
    chk("a64:desc_addr", desc_addr6, 64'hC000);
    desc_ack6 = 1; desc_data6 = {64'h1234_5678_9ABC_DEF0, 16'h0100, 16'h0023};
    @(posedge clk); #1; desc_ack6 = 0;
    for (int c = 0; c < 20 && !tfr_start6; c++) begin @(posedge clk); #1; end
    chk("a64:tfr_start", tfr_start6, 1);
    chk("a64:tfr_addr", tfr_addr6, 64'h1234_5678_9ABC_DEF0);
    chk("a64:tfr_len", tfr_len6, 17'h100);
    tfr_done6 = 1;
    @(posedge clk); #1; tfr_done6 = 0;
    chk("a64:complete", xfer_complete6, 1);
    chk("a64:cur_addr", cur_addr6, 64'hC00C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
